// File: rtl/controle_pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package controle_pipeline_pkg;

    localparam int unsigned LARG_REG = 5;
    localparam logic [LARG_REG-1:0] REG_ZERO = '0;

    typedef enum logic {
        NORMAL = 1'b0,
        ESPERA = 1'b1
    } estado_t;

endpackage

// File: rtl/controle_pipeline_detector_risco.sv
// Combinational load-use comparator: a load in EX feeds a register read by the ID instruction.
module detector_risco
    import controle_pipeline_pkg::*;
(
    input  logic [LARG_REG-1:0] id_rs,
    input  logic [LARG_REG-1:0] id_rt,
    input  logic                id_usa_rt,
    input  logic [LARG_REG-1:0] ex_rt,
    input  logic                ex_le_mem,
    output logic                carga_uso_c
);

    // $zero is never a real dependency, so a load targeting it never stalls.
    assign carga_uso_c = ex_le_mem && (ex_rt != REG_ZERO) &&
                         ((ex_rt == id_rs) || (id_usa_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/controle_pipeline.sv
// Hazard and stall sequencer for the 5-stage core: bubbles, branch flushes, memory-wait freeze.
// Optional perf counters are built only when CONTROLE_CONTADORES_EN is defined.
module controle_pipeline
    import controle_pipeline_pkg::*;
#(
    parameter int unsigned TEMPO_MAX = 1023,
    parameter int unsigned LARG_CONT = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [LARG_REG-1:0]  id_rs,
    input  logic [LARG_REG-1:0]  id_rt,
    input  logic                 id_usa_rt,
    input  logic [LARG_REG-1:0]  ex_rt,
    input  logic                 ex_le_mem,
    input  logic                 ex_desvio,
    input  logic                 mem_acesso,
    input  logic                 mem_ocupada,
    output logic                 pc_escreve,
    output logic                 parada_ifid,
    output logic                 parada_idex,
    output logic                 parada_exmem,
    output logic                 parada_memwb,
    output logic                 limpar_ifid,
    output logic                 limpar_idex,
    output logic                 limpar_exmem,
    output logic                 limpar_memwb,
    output logic                 erro_tempo,
    output logic [LARG_CONT-1:0] cont_bolhas,
    output logic [LARG_CONT-1:0] cont_espera,
    output logic [LARG_CONT-1:0] cont_desvios
);

    localparam int unsigned LARG_TEMPO = $clog2(TEMPO_MAX + 1);
    localparam logic [LARG_TEMPO-1:0] TEMPO_LIM = LARG_TEMPO'(TEMPO_MAX);
    localparam logic [LARG_TEMPO-1:0] TEMPO_ULT = LARG_TEMPO'(TEMPO_MAX - 1);

    estado_t               estado;
    estado_t               estado_prox;
    logic [LARG_TEMPO-1:0] tempo;
    logic                  lu;
    logic                  mw;
    logic                  congela;
    logic                  estouro;

    detector_risco u_detector_risco (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_usa_rt   (id_usa_rt),
        .ex_rt       (ex_rt),
        .ex_le_mem   (ex_le_mem),
        .carga_uso_c (lu)
    );

    assign mw = mem_acesso && mem_ocupada;

    always_ff @(posedge clock) begin
        if (!reset_n) estado <= NORMAL;
        else          estado <= estado_prox;
    end

    // Mealy control: outputs settle before the edge at which the pipeline registers sample.
    always_comb begin
        estado_prox  = estado;
        congela      = 1'b0;
        estouro      = 1'b0;
        pc_escreve   = 1'b0;
        parada_ifid  = 1'b0;
        parada_idex  = 1'b0;
        parada_exmem = 1'b0;
        parada_memwb = 1'b0;
        limpar_ifid  = 1'b0;
        limpar_idex  = 1'b0;
        limpar_exmem = 1'b0;
        limpar_memwb = 1'b0;
        if (!reset_n) begin
            estado_prox  = NORMAL;
            limpar_ifid  = 1'b1;
            limpar_idex  = 1'b1;
            limpar_exmem = 1'b1;
            limpar_memwb = 1'b1;
        end else begin
            case (estado)
                NORMAL: begin
                    if (mw) begin
                        estado_prox = ESPERA;
                        congela     = 1'b1;
                    end
                end
                ESPERA: begin
                    if (!mem_ocupada) begin
                        estado_prox = NORMAL;
                    end else begin
                        congela = 1'b1;
                        if (tempo >= TEMPO_ULT) begin
                            estouro     = 1'b1;
                            estado_prox = NORMAL;
                        end
                    end
                end
                default: estado_prox = NORMAL;
            endcase
            // Freeze IF..EX and kill MEM/WB so the stalled access cannot write back twice.
            if (congela) begin
                parada_ifid  = 1'b1;
                parada_idex  = 1'b1;
                parada_exmem = 1'b1;
                limpar_memwb = 1'b1;
            end else if (ex_desvio) begin
                pc_escreve  = 1'b1;
                limpar_ifid = 1'b1;
                limpar_idex = 1'b1;
            end else if (lu) begin
                parada_ifid = 1'b1;
                limpar_idex = 1'b1;
            end else begin
                pc_escreve = 1'b1;
            end
        end
    end

    // Counts frozen cycles including the entry cycle; saturates at the limit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tempo <= '0;
        end else if (congela) begin
            if (tempo != TEMPO_LIM) tempo <= tempo + 1'b1;
        end else begin
            tempo <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n)     erro_tempo <= 1'b0;
        else if (estouro) erro_tempo <= 1'b1;
    end

`ifdef CONTROLE_CONTADORES_EN
    logic bolha;
    logic flush;
    logic [LARG_CONT-1:0] bolhas_q;
    logic [LARG_CONT-1:0] espera_q;
    logic [LARG_CONT-1:0] desvios_q;

    assign bolha = reset_n && !congela && !ex_desvio && lu;
    assign flush = reset_n && !congela && ex_desvio;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bolhas_q  <= '0;
            espera_q  <= '0;
            desvios_q <= '0;
        end else begin
            if (bolha)   bolhas_q  <= bolhas_q + 1'b1;
            if (congela) espera_q  <= espera_q + 1'b1;
            if (flush)   desvios_q <= desvios_q + 1'b1;
        end
    end

    assign cont_bolhas  = bolhas_q;
    assign cont_espera  = espera_q;
    assign cont_desvios = desvios_q;
`else
    assign cont_bolhas  = '0;
    assign cont_espera  = '0;
    assign cont_desvios = '0;
`endif

endmodule

// File: doc/controle_pipeline.md
# controle_pipeline

Hazard and stall sequencer for the 5-stage MIPS32 core. Drives the `parada`/`limpar` inputs of the four `RegPipeline` instances (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. Resolves three hazard types:
- load-use hazards, by inserting a bubble;
- taken branches/jumps resolved in EX, by flushing;
- multi-cycle data-memory/UART waits, by freezing the pipe with a timeout.

## Interface
- `TEMPO_MAX`, default 1023: maximum consecutive wait cycles before a timeout.
- `LARG_CONT`, default 32: width of the performance counters.

Ports:
- `clock`  in  1  core clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_usa_rt`  in  1  the ID instruction reads `rt`.
- `ex_rt`  in  5  destination register of the instruction in EX.
- `ex_le_mem`  in  1  the EX instruction is a load.
- `ex_desvio`  in  1  a branch was taken or a jump resolved in EX.
- `mem_acesso`  in  1  the MEM stage holds a load or store.
- `mem_ocupada`  in  1  data memory/UART is not ready this cycle.
- `pc_escreve`  out  1  PC update enable.
- `parada_ifid`, `parada_idex`, `parada_exmem`, `parada_memwb`  out  1 each  hold the register.
- `limpar_ifid`, `limpar_idex`, `limpar_exmem`, `limpar_memwb`  out  1 each  clear the register.
- `erro_tempo`  out  1  sticky timeout flag.
- `cont_bolhas`, `cont_espera`, `cont_desvios`  out  `LARG_CONT` each  performance counters.

## Operation
- The FSM state is registered. All `parada`/`limpar`/`pc_escreve` outputs are combinational (Mealy) from the state and current inputs, so they are valid before the edge at which the pipeline registers sample.
- States: `NORMAL`, `ESPERA`.
- `reset_n`=0:
  - state goes to `NORMAL`; `erro_tempo`, the wait counter and all perf counters go to 0;
  - outputs are forced to all `limpar_*`=1, all `parada_*`=0, `pc_escreve`=0, so the pipeline clears on the same edge.
- Load-use condition `lu` = `ex_le_mem` && `ex_rt`≠0 && (`ex_rt`==`id_rs` || (`id_usa_rt` && `ex_rt`==`id_rt`)).
- Memory-wait condition `mw` = `mem_acesso` && `mem_ocupada`.
- Priority in `NORMAL`: `mw` > `ex_desvio` > `lu` > none.
  - `mw`: state goes to `ESPERA`; this cycle already applies the `ESPERA` outputs.
  - `ex_desvio`: `limpar_ifid`=1, `limpar_idex`=1, `pc_escreve`=1 (the PC loads the target); all other outputs 0.
  - `lu`: `pc_escreve`=0, `parada_ifid`=1, `limpar_idex`=1 (bubble); all other outputs 0.
  - none: `pc_escreve`=1, all `parada_*`/`limpar_*` 0.
- `ESPERA` outputs:
  - `pc_escreve`=0;
  - `parada_ifid`=`parada_idex`=`parada_exmem`=1;
  - `limpar_memwb`=1, so no duplicate writeback occurs.
- `ESPERA` transitions:
  - `mem_ocupada`=0: return to `NORMAL`, with `NORMAL` outputs evaluated in that same cycle (the MEM result passes).
  - Wait counter reaches `TEMPO_MAX`: set `erro_tempo`, return to `NORMAL`, and the access is abandoned.
- `ex_desvio` and `lu` during `ESPERA` are deferred, not lost: ID/EX is frozen, so they re-present after the wait.
- The wait counter clears on every `NORMAL` cycle and saturates at `TEMPO_MAX`.
- `erro_tempo` clears only on reset.

## Timing
- Zero-cycle control latency: outputs respond to inputs in the same cycle.
- Load-use costs exactly 1 bubble.
- A branch flush costs 2 slots.
- A memory wait of N busy cycles freezes the pipe for N cycles. Entry into `ESPERA` occurs on the first edge where `mw`=1.
- `reset_n` asserted mid-`ESPERA` returns the block to `NORMAL` on the next edge, overriding everything.
- The `limpar` output has precedence over `parada` inside `RegPipeline`. The block never asserts both on the same register.

## Configuration
- `CONTROLE_CONTADORES_EN` defined:
  - `cont_bolhas` increments on each `lu` bubble cycle;
  - `cont_espera` increments on each `ESPERA` cycle;
  - `cont_desvios` increments on each flush cycle;
  - all counters wrap at 2^`LARG_CONT`.
- Undefined: the counter ports remain but are tied to 0, and no counter flops are synthesized.

## Structure
- Package `controle_pipeline_pkg` holds:
  - the state enumeration (`NORMAL`, `ESPERA`);
  - the register-index width constant (5);
  - the register-zero constant.
- Sub-module `detector_risco` is the combinational `lu` comparator. It is reusable by a future forwarding unit.
- Timeout counter, FSM and perf counters stay in the top module.

## Test plan
- Load-use: `ex_le_mem`=1, `ex_rt`=8, `id_rs`=8 → `pc_escreve`=0, `parada_ifid`=1, `limpar_idex`=1 for 1 cycle; `cont_bolhas`=1.
- Same stimulus with `ex_rt`=0 → no stall; `pc_escreve`=1.
- `ex_desvio`=1 and `lu`=1 simultaneously → flush wins: `limpar_ifid`=`limpar_idex`=1, `pc_escreve`=1.
- `mem_acesso`=1, `mem_ocupada`=1 for 3 cycles → 3 cycles with IF/ID/EX stages held, `limpar_memwb`=1; back to `NORMAL` on cycle 4; `cont_espera`=3.
- `TEMPO_MAX`=4 with `mem_ocupada` stuck at 1 → `erro_tempo`=1 after 4 cycles, state `NORMAL`; the flag persists until reset.
- `reset_n`=0 during `ESPERA` → next edge: state `NORMAL`, all `limpar_*`=1, counters 0, `erro_tempo`=0.
